// File: rtl/window_seq.sv
// -----------------------------------------------------------------------------
// window_seq
// Sequencer for a 1-bit binarized 3x3 line-buffer window. It streams a binary
// feature map in raster order out of a 1-cycle-latency buffer into the window,
// appends W-1 zero flush shifts so the last column reaches the taps, and flags
// each complete 3x3 window position to the XNOR-popcount stage through a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   go, cfg_layer     frame start pulse and layer select (sampled on start)
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   rd_en, rd_addr    feature-buffer read strobe and raster pixel address
//   rd_data           pixel returned the cycle after rd_en
//   win_shift/din     window shift enable and serial data
//   win_state         window tap select (latched layer)
//   win_valid         taps currently hold a complete 3x3 window
//   out_ready         downstream accepts the presented window
//   out_row/out_col   top-left coordinate of the presented window
// -----------------------------------------------------------------------------
module window_seq #(
  parameter int W0     = 28,
  parameter int W1     = 26,
  parameter int ADDR_W = 10,
  parameter int CW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              cfg_layer,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              win_shift,
  output logic              win_din,
  output logic              win_state,
  output logic              win_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_row,
  output logic [CW-1:0]     out_col
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic              layer_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_pend_r;
  logic              skid_full_r;
  logic              skid_data_r;
  logic [ADDR_W-1:0] shift_cnt_r;
  logic [CW-1:0]     qr_r, qc_r;
  logic              win_valid_r;
  logic [CW-1:0]     out_row_r, out_col_r;

  logic [CW-1:0]     w_s;
  logic [ADDR_W-1:0] n_s, total_s, qstart_s;
  logic              stall_s;
  logic              start_s, rd_en_s, shift_s, din_s, capture_s, drain_s;
  logic              q_hit_s, set_s;
  logic [CW-1:0]     nqr_s, nqc_s;

  // Frame geometry derived from the latched layer.
  assign w_s      = layer_r ? CW'(W1) : CW'(W0);
  assign n_s      = layer_r ? ADDR_W'(W1 * W1) : ADDR_W'(W0 * W0);
  // Total shifts per frame: N pixels plus W-1 zero flush shifts.
  assign total_s  = n_s + ADDR_W'(w_s) - ADDR_W'(1'b1);
  // Shift index whose result first places pixel 0 at the bottom tap.
  assign qstart_s = ADDR_W'(w_s) - ADDR_W'(1'b1);
  assign stall_s  = win_valid_r & ~out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus read/shift/skid control.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    rd_en_s   = 1'b0;
    shift_s   = 1'b0;
    din_s     = 1'b0;
    capture_s = 1'b0;
    drain_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_s = RUN;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Skid data is older than anything returning, so it shifts first.
        // A pending return and a full skid never coexist: rd_en needs an
        // empty skid and a capture needs a stall, which blocks rd_en.
        if (!stall_s && skid_full_r) begin
          shift_s = 1'b1;
          din_s   = skid_data_r;
          drain_s = 1'b1;
        end else if (!stall_s && rd_pend_r) begin
          shift_s = 1'b1;
          din_s   = rd_data;
        end else if (stall_s && rd_pend_r) begin
          capture_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
        rd_en_s = (rd_addr_r < n_s) && !skid_full_r && !stall_s;
        if (shift_s && (shift_cnt_r == n_s - ADDR_W'(1'b1))) begin
          state_s = FLUSH;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (!stall_s && (shift_cnt_r != total_s)) begin
          shift_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
        // Leave once every shift is done and the final window is gone
        // (or is being accepted this cycle).
        if ((shift_cnt_r == total_s) && (!win_valid_r || out_ready)) begin
          state_s = DONE;
        end else begin
          state_s = FLUSH;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Position of the bottom-tap pixel q after this cycle's shift, and whether
  // that position completes a 3x3 window.
  always_comb begin
    nqr_s   = qr_r;
    nqc_s   = qc_r;
    q_hit_s = 1'b0;
    if (shift_s && (shift_cnt_r >= qstart_s)) begin
      q_hit_s = 1'b1;
      if (shift_cnt_r == qstart_s) begin
        nqr_s = '0;
        nqc_s = '0;
      end else if (qc_r == w_s - CW'(1'b1)) begin
        nqr_s = qr_r + CW'(1'b1);
        nqc_s = '0;
      end else begin
        nqc_s = qc_r + CW'(1'b1);
      end
    end else begin
      q_hit_s = 1'b0;
    end
    set_s = q_hit_s && (nqr_s >= CW'(2'd2)) && (nqc_s >= CW'(2'd2));
  end

  // Datapath: read address, read pipeline, skid, shift/position counters and
  // the registered window handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_r     <= 1'b0;
      rd_addr_r   <= '0;
      rd_pend_r   <= 1'b0;
      skid_full_r <= 1'b0;
      skid_data_r <= 1'b0;
      shift_cnt_r <= '0;
      qr_r        <= '0;
      qc_r        <= '0;
      win_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_col_r   <= '0;
    end else if (start_s) begin
      layer_r     <= cfg_layer;
      rd_addr_r   <= '0;
      rd_pend_r   <= 1'b0;
      skid_full_r <= 1'b0;
      skid_data_r <= 1'b0;
      shift_cnt_r <= '0;
      qr_r        <= '0;
      qc_r        <= '0;
      win_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_col_r   <= '0;
    end else begin
      rd_pend_r <= rd_en_s;
      if (rd_en_s) begin
        rd_addr_r <= rd_addr_r + ADDR_W'(1'b1);
      end
      if (capture_s) begin
        skid_full_r <= 1'b1;
        skid_data_r <= rd_data;
      end else if (drain_s) begin
        skid_full_r <= 1'b0;
      end
      if (shift_s) begin
        shift_cnt_r <= shift_cnt_r + ADDR_W'(1'b1);
      end
      if (q_hit_s) begin
        qr_r <= nqr_s;
        qc_r <= nqc_s;
      end
      // A shift can only happen when not stalled, so a set here never
      // overwrites a window that is still waiting to be accepted.
      if (set_s) begin
        win_valid_r <= 1'b1;
        out_row_r   <= nqr_s - CW'(2'd2);
        out_col_r   <= nqc_s - CW'(2'd2);
      end else if (win_valid_r && out_ready) begin
        win_valid_r <= 1'b0;
      end
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign rd_en     = rd_en_s;
  assign rd_addr   = rd_addr_r;
  assign win_shift = shift_s;
  assign win_din   = din_s;
  assign win_state = layer_r;
  assign win_valid = win_valid_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;

endmodule

// File: tb/tb_window_seq.sv
// -----------------------------------------------------------------------------
// tb_window_seq
// Self-checking bench for window_seq. A random binary image is served by a
// 1-cycle-latency buffer model. The expected pixel stream (image then W-1
// zeros) and the expected window list (row-major over (W-2)x(W-2) top-left
// positions, each due right after shift p = (r+2)*W + (c+2) + W-1) are
// computed directly from the frame geometry.
// -----------------------------------------------------------------------------
module tb_window_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       cfg_layer = 1'b0;
  logic       busy, done, rd_en;
  logic [9:0] rd_addr;
  logic       rd_data = 1'b0;
  logic       win_shift, win_din, win_state, win_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_row, out_col;

  int  compared = 0;
  int  failed   = 0;
  bit  img [0:1023];

  window_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .cfg_layer (cfg_layer),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_shift (win_shift),
    .win_din   (win_din),
    .win_state (win_state),
    .win_valid (win_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  // Feature buffer: 1-cycle read latency, random junk when no read is pending.
  always @(posedge clk) begin
    rd_data <= rd_en ? img[rd_addr] : 1'($urandom);
  end

  // Runs one frame. mode 0: always ready, 1: random ready, 2: five-cycle
  // stall at window (3,7). go_at: cycle of a spurious go. abort_at: read
  // index at which reset is asserted mid-frame (-1 for none).
  task automatic run_frame(input bit layer, input int mode, input int go_at, input int abort_at);
    int w, n, nwin, rd_cnt, sh_cnt, wi, cyc, bp_left, rel_k, exp_r, exp_c, exp_p;
    bit armed, fin, aborted, stall, exp_din;
    w = layer ? 26 : 28;
    n = w * w;
    nwin = (w - 2) * (w - 2);
    for (int i = 0; i < n; i++) img[i] = 1'($urandom);
    rd_cnt = 0; sh_cnt = 0; wi = 0; cyc = 0; bp_left = 0; rel_k = 0;
    armed = 0; fin = 0; aborted = 0;
    @(negedge clk);
    go = 1'b1; cfg_layer = layer; out_ready = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0) begin failed++; $display("FAIL busy_before_go got %0b want 0", busy); end
    while (!fin && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      go = (cyc == go_at);
      cfg_layer = ~layer;
      if (mode == 2 && !armed && win_valid === 1'b1 && out_row == 5'd3 && out_col == 5'd7) begin
        armed = 1; bp_left = 5;
      end
      if (bp_left > 0) begin
        out_ready = 1'b0; bp_left--;
      end else begin
        out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (armed) rel_k++;
      end
      #1;
      stall = win_valid & ~out_ready;
      if (abort_at >= 0 && rd_en === 1'b1 && rd_cnt == abort_at) begin
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, done, rd_en, rd_addr, win_shift, win_din, win_state, win_valid, out_row, out_col} !== 28'd0) begin
          failed++;
          $display("FAIL async_reset outputs got busy=%0b done=%0b rd_en=%0b addr=%0d sh=%0b st=%0b v=%0b row=%0d col=%0d want all 0",
                   busy, done, rd_en, rd_addr, win_shift, win_state, win_valid, out_row, out_col);
        end
        aborted = 1;
        break;
      end
      compared++;
      if (busy !== 1'b1 || win_state !== layer) begin
        failed++; $display("FAIL frame_status cyc=%0d busy=%0b win_state=%0b want 1/%0b", cyc, busy, win_state, layer);
      end
      if (rd_en === 1'b1) begin
        compared++;
        if (rd_addr !== 10'(rd_cnt) || rd_cnt >= n || stall) begin
          failed++; $display("FAIL read addr=%0d want %0d (n=%0d stall=%0b)", rd_addr, rd_cnt, n, stall);
        end
        rd_cnt++;
      end
      if (win_shift === 1'b1) begin
        exp_din = (sh_cnt < n) ? img[sh_cnt] : 1'b0;
        compared++;
        if (win_din !== exp_din || stall || sh_cnt >= n + w - 1) begin
          failed++; $display("FAIL shift p=%0d din=%0b want %0b stall=%0b", sh_cnt, win_din, exp_din, stall);
        end
      end
      if (win_valid === 1'b1 && out_ready) begin
        exp_r = wi / (w - 2);
        exp_c = wi % (w - 2);
        exp_p = (exp_r + 2) * w + (exp_c + 2) + w - 1;
        compared++;
        if (wi >= nwin || out_row !== 5'(exp_r) || out_col !== 5'(exp_c) || sh_cnt != exp_p + 1) begin
          failed++; $display("FAIL window #%0d got (%0d,%0d) after %0d shifts want (%0d,%0d) after %0d",
                             wi, out_row, out_col, sh_cnt, exp_r, exp_c, exp_p + 1);
        end
        wi++;
      end
      if (mode == 2 && armed && !out_ready) begin
        compared++;
        if (win_valid !== 1'b1 || out_row !== 5'd3 || out_col !== 5'd7 || win_shift !== 1'b0 || rd_en !== 1'b0) begin
          failed++; $display("FAIL stall_hold v=%0b row=%0d col=%0d sh=%0b rd=%0b want 1/3/7/0/0",
                             win_valid, out_row, out_col, win_shift, rd_en);
        end
      end
      if (mode == 2 && rel_k == 1) begin
        compared++;
        if (win_shift !== 1'b1 || rd_en !== 1'b0) begin
          failed++; $display("FAIL skid_drain sh=%0b rd=%0b want 1/0", win_shift, rd_en);
        end
      end
      if (mode == 2 && rel_k == 2) begin
        compared++;
        if (win_shift !== 1'b0 || rd_en !== 1'b1) begin
          failed++; $display("FAIL bubble sh=%0b rd=%0b want 0/1", win_shift, rd_en);
        end
      end
      if (win_shift === 1'b1) sh_cnt++;
      if (done === 1'b1) begin
        compared++;
        if (wi != nwin || sh_cnt != n + w - 1 || rd_cnt != n || win_valid !== 1'b0) begin
          failed++; $display("FAIL frame_end windows=%0d shifts=%0d reads=%0d v=%0b want %0d/%0d/%0d/0",
                             wi, sh_cnt, rd_cnt, win_valid, nwin, n + w - 1, n);
        end
        fin = 1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      if (!fin) begin
        compared++; failed++; $display("FAIL timeout no done after %0d cycles want done", cyc);
      end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        go = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
          failed++; $display("FAIL post_frame k=%0d busy=%0b done=%0b rd_en=%0b want 0/0/0", k, busy, done, rd_en);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    compared++;
    if ({busy, done, rd_en, rd_addr, win_shift, win_din, win_state, win_valid, out_row, out_col} !== 28'd0) begin
      failed++; $display("FAIL reset_state outputs not all zero busy=%0b rd_en=%0b v=%0b", busy, rd_en, win_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_layer0();        run_frame(1'b0, 0, -1, -1);   endtask
  task automatic test_layer1();        run_frame(1'b1, 0, -1, -1);   endtask
  task automatic test_backpressure();  run_frame(1'b0, 2, -1, -1);   endtask
  task automatic test_random_ready();  run_frame(1'b1, 1, -1, -1); run_frame(1'b0, 1, -1, -1); endtask
  task automatic test_go_ignored();    run_frame(1'b0, 0, 300, -1); run_frame(1'b1, 0, 690, -1); endtask
  task automatic test_reset_mid();     run_frame(1'b1, 0, -1, 400); run_frame(1'b0, 0, -1, -1); endtask

  initial begin
    test_reset();
    test_layer0();
    test_layer1();
    test_backpressure();
    test_random_ready();
    test_go_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
